// File: rtl/fetch_ir_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ir_stage
// Purpose  : Instruction-fetch stage for the MIPS cores. Owns the PC, drives
//            a req/ack instruction-memory port and registers each returned
//            word into IR together with a valid flag, its PC and PC+4.
//            Handles downstream stall (one-word skid) and branch/jump
//            redirect, including squash of a fetch that is still in flight.
// Ports    : clk, reset             - clock (rising edge), sync active-high reset
//            stall                  - downstream hold of IR/ir_valid/pc_out
//            redirect, redirect_pc  - taken branch/jump and its target
//            imem_req, imem_addr    - fetch request / address (state-decoded)
//            imem_rdata, imem_ack   - returned word / one-cycle completion
//            IR, ir_valid           - registered instruction and valid flag
//            pc_out, pc_plus4       - PC of the word in IR and PC+4
//            fetch_count            - instructions loaded into IR
//                                     (only with FETCH_PERF_CNT_EN)
// Options  : `define FETCH_PERF_CNT_EN to add the fetch_count port/counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ir_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] IR,
    output logic        ir_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0] fetch_count
`endif
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FETCH  = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;
    localparam logic [1:0] c_ST_SQUASH = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;        // next address to fetch
    logic [31:0] r_sq_addr;   // address of the request being squashed
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc_plus4;
    logic [31:0] r_skid;
    logic [31:0] r_skid_pc;

    logic [31:0] w_pc_inc;
    logic [31:0] w_redir_pc;
    logic        w_ir_load;

    assign w_pc_inc   = r_pc + 32'd4;
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // A word enters IR either straight from memory or out of the skid.
    assign w_ir_load = !redirect && !stall &&
                       (((r_state == c_ST_FETCH) && imem_ack) || (r_state == c_ST_HOLD));

    // Request/address decode purely from state and registers, so stall and
    // redirect never reach the memory port combinationally. While squashing,
    // the address must stay at the outstanding request, not the new target.
    assign imem_req  = (r_state == c_ST_FETCH) || (r_state == c_ST_SQUASH);
    assign imem_addr = (r_state == c_ST_SQUASH) ? r_sq_addr : r_pc;

    assign IR       = r_ir;
    assign ir_valid = r_ir_valid;
    assign pc_out   = r_pc_out;
    assign pc_plus4 = r_pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_pc       <= RESET_PC;
            r_sq_addr  <= RESET_PC;
            r_ir       <= NOP_WORD;
            r_ir_valid <= 1'b0;
            r_pc_out   <= RESET_PC;
            r_pc_plus4 <= RESET_PC + 32'd4;
            r_skid     <= NOP_WORD;
            r_skid_pc  <= 32'd0;
        end else begin
            if (redirect && (r_state != c_ST_IDLE)) begin
                // Redirect wins over stall and ack: flush IR and the skid.
                r_pc       <= w_redir_pc;
                r_ir       <= NOP_WORD;
                r_ir_valid <= 1'b0;
                r_skid     <= NOP_WORD;
                r_skid_pc  <= 32'd0;
                case (r_state)
                    c_ST_FETCH: begin
                        if (imem_ack) begin
                            r_state <= c_ST_FETCH;      // returned word dropped
                        end else begin
                            r_state   <= c_ST_SQUASH;   // wait out the old request
                            r_sq_addr <= r_pc;
                        end
                    end
                    c_ST_HOLD:   r_state <= c_ST_FETCH;
                    default:     r_state <= c_ST_SQUASH; // SQUASH keeps old address
                endcase
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_state <= c_ST_FETCH;
                        if (redirect) begin
                            r_pc       <= w_redir_pc;
                            r_ir       <= NOP_WORD;
                            r_ir_valid <= 1'b0;
                        end
                    end
                    c_ST_FETCH: begin
                        if (imem_ack) begin
                            r_pc <= w_pc_inc;
                            if (stall) begin
                                r_skid    <= imem_rdata;
                                r_skid_pc <= r_pc;
                                r_state   <= c_ST_HOLD;
                            end else begin
                                r_ir       <= imem_rdata;
                                r_ir_valid <= 1'b1;
                                r_pc_out   <= r_pc;
                                r_pc_plus4 <= w_pc_inc;
                            end
                        end else if (!stall) begin
                            r_ir_valid <= 1'b0;         // bubble while waiting
                        end
                    end
                    c_ST_HOLD: begin
                        if (!stall) begin
                            r_ir       <= r_skid;
                            r_ir_valid <= 1'b1;
                            r_pc_out   <= r_skid_pc;
                            r_pc_plus4 <= r_skid_pc + 32'd4;
                            r_state    <= c_ST_FETCH;
                        end
                    end
                    c_ST_SQUASH: begin
                        if (imem_ack) begin
                            r_state <= c_ST_FETCH;      // stale word discarded
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
        end else if (w_ir_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    logic w_unused_load;
    assign w_unused_load = w_ir_load;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_ir_stage.md
Name: fetch_ir_stage

Overview:
- Instruction-fetch stage of the single-cycle/multi-cycle MIPS cores; sits directly upstream of the IR field splitter.
- Owns the PC and drives a req/ack instruction-memory port.
- Registers each returned 32-bit word into IR, with a valid flag, its PC and PC+4.
- Supports downstream stall and branch/jump redirect, including squash of an in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, value IR takes on reset/flush (MIPS sll $0,$0,0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
stall  in  1  downstream hold; IR/ir_valid/pc_out must not change while high (except redirect/reset)
redirect  in  1  taken branch/jump this cycle
redirect_pc  in  32  target PC; bits [1:0] ignored (forced 00)
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  32  fetch address, stable while imem_req high
imem_rdata  in  32  instruction word, valid when imem_ack high
imem_ack  in  1  one-cycle completion pulse; only legal while imem_req high; may arrive same cycle as req
IR  out  32  registered instruction to field splitter
ir_valid  out  1  IR holds a live instruction
pc_out  out  32  PC of instruction in IR
pc_plus4  out  32  pc_out + 4 (mod 2^32)

Behaviour:
- Reset values (sync, priority over all): pc=RESET_PC, IR=NOP_WORD, ir_valid=0, pc_out=RESET_PC, pc_plus4=RESET_PC+4, imem_req=0, state=IDLE, skid empty.
- Reset mid-request: req drops next cycle. A late ack after reset is ignored by the bench contract.
- States:
  - IDLE: one cycle after reset, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; one word is parked in the skid register.
  - SQUASH: imem_req=1 at the old address; the returning word is discarded.
- FETCH with ack and !stall:
  - IR<=imem_rdata, ir_valid<=1, pc_out<=pc, pc_plus4<=pc+4, pc<=pc+4.
  - Stay in FETCH. Throughput is one instruction per cycle with zero-wait memory.
- FETCH with ack and stall:
  - skid<=imem_rdata, skid_pc<=pc, pc<=pc+4, go to HOLD.
  - IR is unchanged.
- FETCH, no ack: hold req and addr, IR unchanged. If no ack and stall=0, ir_valid<=0 (bubble).
- HOLD:
  - stall=1: stay in HOLD, everything frozen.
  - stall=0: IR<=skid, pc_out<=skid_pc, ir_valid<=1, go to FETCH.
- Redirect, priority over stall and ack, any state except IDLE:
  - pc<=redirect_pc&~3, IR<=NOP_WORD, ir_valid<=0, skid cleared.
  - Next state:
    - FETCH, no ack this cycle: SQUASH.
    - FETCH, ack this cycle: word dropped, next state FETCH.
    - HOLD: FETCH.
    - SQUASH: stay SQUASH, with the new target latched.
- SQUASH: on ack, drop the data and go to FETCH at the redirected pc. A redirect in IDLE is applied to pc; the state still moves to FETCH.
- Arithmetic: all PC math is 32-bit unsigned. 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag. pc[1:0] is always 00.
- No combinational path from stall/redirect to imem_addr. imem_req is a registered or state-decoded output only.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds output fetch_count [31:0].
  - Increments by 1 on every instruction written into IR from FETCH or HOLD, i.e. each ir_valid 0/1→1 load.
  - Squashed or dropped words are not counted.
  - Reset to 0; wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, zero-wait memory (ack same cycle), imem_rdata=addr|0x1000_0000 → IR sequence 0x1000_0000, 0x1000_0004, 0x1000_0008 on consecutive cycles; pc_plus4=pc_out+4; ir_valid=1 from 2nd cycle after reset.
- Ack delayed 3 cycles per request → imem_addr stable during wait, ir_valid=0 bubbles, IR updates once per ack.
- stall=1 for 4 cycles while ack arrives at pc=0x10 → IR frozen; HOLD entered; stall release loads word of 0x10 with pc_out=0x10; next fetch at 0x14.
- redirect to 0x0000_0103 while request to 0x20 outstanding, ack 2 cycles later → IR=NOP_WORD, ir_valid=0; word for 0x20 never appears; next imem_addr=0x0000_0100.
- Redirect to 0xFFFF_FFFC, zero-wait → pc_out=0xFFFF_FFFC then 0x0000_0000; pc_plus4=0x0000_0000 then 0x0000_0004.
- Reset asserted during stall+HOLD → next cycle IR=NOP_WORD, ir_valid=0, imem_req=0, pc=RESET_PC. With FETCH_PERF_CNT_EN, fetch_count=0.
